// File: rtl/if_id_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO of {pc, ins}; enqueue-to-id_* latency 1 cycle, no bypass.
// Backpressure: pc_wr = !full from registered count only; flush empties the queue on the next edge.
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_valid,
   input  logic [31:0]   if_pc,
   input  logic [31:0]   if_ins,
   output logic          pc_wr,
   input  logic          id_ready,
   output logic          id_valid,
   output logic [31:0]   id_pc,
   output logic [31:0]   id_pc4,
   output logic [31:0]   id_ins,
   input  logic          flush,
   output logic [AW:0]   level
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0] pc_mem  [DEPTH];
   logic [31:0] ins_mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count;
   logic          full, empty, enq, deq;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign enq   = if_valid && !full && !flush;
   assign deq   = !empty && id_ready && !flush;

   // Storage is not reset; only entries between rp and wp are ever observed.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[wp]  <= if_pc;
         ins_mem[wp] <= if_ins;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (enq) wp <= wp + 1'b1;
         if (deq) rp <= rp + 1'b1;
         if (enq && !deq)
            count <= count + 1'b1;
         else if (deq && !enq)
            count <= count - 1'b1;
      end
   end

   // Empty queue presents a NOP at PC 0, so id_pc4 still reads 4.
   assign pc_wr    = !full;
   assign id_valid = !empty;
   assign id_pc    = empty ? 32'h0 : pc_mem[rp];
   assign id_ins   = empty ? 32'h0 : ins_mem[rp];
   assign id_pc4   = id_pc + 32'd4;
   assign level    = count;

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue between the fetch stage (PC register, next-PC select, instruction memory) and the decode stage of the pipelined MIPS CPU. It captures the {PC, instruction} pair the fetch stage presents each cycle and holds it in a small FIFO. It drives the PC write-enable as backpressure so fetch stalls when the queue is full. Decode reads entries through a valid/ready handshake, and a flush input discards all buffered entries on a branch or jump redirect.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- AW, 2, pointer width = log2(DEPTH)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears the queue
- if_valid  input  1  fetch stage presents a valid pair this cycle
- if_pc  input  32  PC of the presented instruction
- if_ins  input  32  instruction word read from instruction memory at if_pc
- pc_wr  output  1  PC write-enable to fetch; 1 = fetch may advance
- id_ready  input  1  decode accepts the head entry this cycle
- id_valid  output  1  head entry valid
- id_pc  output  32  PC of head entry
- id_pc4  output  32  id_pc + 4 (sequential next PC for decode and branch-target adders)
- id_ins  output  32  instruction of head entry
- flush  input  1  redirect: discard all entries and this cycle's enqueue
- level  output  AW+1  current entry count, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc[31:0], ins[31:0]}, plus write pointer wp, read pointer rp (AW bits each, wrap modulo DEPTH) and count (AW+1 bits).
- full = (count == DEPTH); empty = (count == 0).
- pc_wr = !full. It is combinational from registered count only and never depends on if_valid, id_ready or flush, so there is no combinational loop through the next-PC mux.
- Enqueue (enq) = if_valid && !full && !flush. Writes {if_pc, if_ins} at wp; wp <= wp+1.
- Dequeue (deq) = id_valid && id_ready && !flush. rp <= rp+1.
- count update: count+1 on enq only, count-1 on deq only, unchanged when both or neither occur.
- Full with id_ready=1: deq occurs, enq is blocked because pc_wr was 0 that cycle. Count drops to DEPTH-1, and fetch resumes on the next cycle.
- Empty: id_valid=0, and id_pc, id_pc4 and id_ins read 0. id_ins=0 is the NOP encoding. id_ready is ignored.
- Non-empty: id_valid=1; id_pc and id_ins show the entry at rp; id_pc4 = id_pc + 4, modulo 2^32 with no carry out.
- flush has priority over everything else. On the next edge, count, wp and rp become 0. Any concurrent enq or deq is suppressed, and storage contents are don't-care.
- No bypass: an entry enqueued at edge N is visible on id_* only after edge N, never in the same cycle.

## Timing
- Reset (asynchronous, immediate):
  - count=0, wp=0, rp=0
  - id_valid=0, id_pc=0, id_pc4=32'h4, id_ins=0
  - pc_wr=1, level=0
- Storage contents need not be reset.
- Enqueue-to-output latency is 1 cycle. Sustained throughput is 1 entry/cycle when if_valid and id_ready stay high.
- Pointer wrap: after DEPTH enqueues, wp returns to 0. Entry order is preserved across the wrap.
- Reset asserted mid-operation drops all entries immediately; no partial state is kept.
- flush together with a full queue: pc_wr is still 0 that cycle, and on the next cycle pc_wr=1 and level=0.

## Test plan
- Reset:
  - Stimulus: assert rst with if_valid=1.
  - Response: id_valid=0, id_ins=0, id_pc4=32'h4, pc_wr=1, level=0 during and after reset.
- Streaming:
  - Stimulus: if_valid=1, id_ready=1, if_pc stepping 32'h3000, 32'h3004, 32'h3008; if_ins = 32'h8C010000, 32'h8C020004, 32'h00221820.
  - Response: the same pairs appear on id_* one cycle later, in order; id_pc4 = 32'h3004, 32'h3008, 32'h300C; level stays 1.
- Fill and backpressure:
  - Stimulus: id_ready=0, if_valid=1 for 6 cycles, DEPTH=4.
  - Response: pc_wr=0 after the 4th enqueue and level=4; the 5th and 6th pairs are not stored; raising id_ready returns 32'h3000 first.
- Full with simultaneous ready:
  - Stimulus: at level=4, set id_ready=1 for 1 cycle.
  - Response: level=3, pc_wr=1 the next cycle; a later enqueue lands after 32'h300C with no loss or duplication.
- Wrap-around:
  - Stimulus: 10 enqueues and 10 dequeues at mixed rates.
  - Response: output PC sequence exactly 32'h3000..32'h3024 step 4; level never exceeds 4.
- Flush:
  - Stimulus: at level=3, assert flush with if_valid=1 and id_ready=1.
  - Response: the next cycle has level=0, id_valid=0 and pc_wr=1; a new pair at 32'h3100 is the next output.
